// File: rtl/ebpc_pkg.sv
// Shared encoder definitions for the shift-streamer arbiter: word and
// length widths, the arbiter state encoding and the code beat record.
package ebpc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LW     = $clog2(DATA_W + 1);

    // Largest legal code length, in the width of a length field.
    localparam logic [LW-1:0] LEN_MAX = LW'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LW-1:0]     len;
        logic              last;
    } code_beat_t;

    // Lengths above DATA_W are illegal; saturate them so the streamer never
    // sees a shift it cannot perform.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/shift_streamer_arb_rr_arb2.sv
// Two-way round-robin grant. The grant itself is combinational; the
// priority pointer only moves when a packet finishes (last-beat handshake),
// so a packet is never preempted.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_src_i,
    output logic       gnt_o,
    output logic       gnt_vld_o
);

    logic ptr_q;

    // Pointer register: after source g completes a packet, the other source
    // gets priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= ~upd_src_i;
        end
    end

    // Grant the pointed-to source if it requests, otherwise the other one.
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_o     = req_i[ptr_q] ? ptr_q : ~ptr_q;
    end

endmodule

// File: rtl/shift_streamer_arb.sv
// Shares one shift_streamer between the ZNZ coder (source 0) and the
// bit-plane coder (source 1). Packets are granted round-robin and forwarded
// with no added latency; end-of-block requests are turned into a flush beat
// and the arbiter waits for the streamer to go idle before the next block.
// Optional per-source statistics counters: define EBPC_ARB_STATS_EN.
//
// Handshake: a beat moves when str_vld_o && str_rdy_i. str_rdy_i is routed
// only to the granted source; the others see rdy = 0. A source must hold
// vld/data/len/last stable until its beat is accepted.
module shift_streamer_arb
    import ebpc_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0][DATA_W-1:0] src_data_i,
    input  logic [1:0][LW-1:0]     src_len_i,
    input  logic [1:0]             src_last_i,
    input  logic [1:0]             src_vld_i,
    output logic [1:0]             src_rdy_o,
    input  logic                   blk_end_i,
    output logic                   blk_done_o,
    output logic [2*DATA_W-1:0]    str_data_o,
    output logic [LW-1:0]          str_shift_o,
    output logic                   str_flush_o,
    output logic                   str_vld_o,
    input  logic                   str_rdy_i,
    input  logic                   str_idle_i,
    output arb_state_t             state_o
`ifdef EBPC_ARB_STATS_EN
    ,
    input  logic                   stat_clr_i,
    output logic [1:0][31:0]       stat_bits_o,
    output logic [1:0][15:0]       stat_pkts_o
`endif
);

    arb_state_t state_q, state_d;
    logic       lock_q, lock_d;
    logic       flush_pend_q;
    logic       dirty_q;
    logic       done_q;

    logic       gnt;
    logic       gnt_vld;
    logic       sel;
    logic       fwd;
    logic       fwd_vld;
    logic       xfer;
    logic       last_xfer;
    logic       done_set;
    code_beat_t beat;

    rr_arb2 u_rr_arb2 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (src_vld_i),
        .upd_i     (last_xfer),
        .upd_src_i (sel),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld)
    );

    // In IDLE the fresh grant is used directly so the first beat can move in
    // the grant cycle; while locked the registered owner is used.
    assign sel       = (state_q == LOCK) ? lock_q : gnt;
    assign fwd       = (state_q == LOCK) || ((state_q == IDLE) && !flush_pend_q && gnt_vld);
    assign beat.data = src_data_i[sel];
    assign beat.len  = clamp_len(src_len_i[sel]);
    assign beat.last = src_last_i[sel];
    assign fwd_vld   = fwd && src_vld_i[sel];
    assign xfer      = fwd_vld && str_rdy_i;
    assign last_xfer = xfer && beat.last;

    // Block completes either when a drained flush finds the streamer idle, or
    // immediately when nothing was written since the last block.
    assign done_set  = ((state_q == IDLE) && flush_pend_q && !dirty_q) ||
                       ((state_q == DRAIN) && str_idle_i);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (flush_pend_q) begin
                    if (dirty_q) begin
                        state_d = FLUSH;
                    end
                end else if (gnt_vld) begin
                    lock_d = gnt;
                    if (!last_xfer) begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (last_xfer) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (str_rdy_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (str_idle_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: forward the selected source, or present the flush beat.
    always_comb begin
        src_rdy_o   = '0;
        str_vld_o   = 1'b0;
        str_flush_o = 1'b0;
        str_data_o  = '0;
        str_shift_o = '0;
        if (state_q == FLUSH) begin
            str_vld_o   = 1'b1;
            str_flush_o = 1'b1;
        end else if (fwd) begin
            src_rdy_o[sel] = str_rdy_i;
            str_vld_o      = fwd_vld;
            str_data_o     = {beat.data, {DATA_W{1'b0}}};
            str_shift_o    = beat.len;
        end
    end

    // Block bookkeeping: pending flush, written-since-flush flag, done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_pend_q <= 1'b0;
            dirty_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done_set;
            if (done_set) begin
                flush_pend_q <= 1'b0;
            end else if (blk_end_i) begin
                flush_pend_q <= 1'b1;
            end
            if (done_set) begin
                dirty_q <= 1'b0;
            end else if (xfer && (beat.len != '0)) begin
                dirty_q <= 1'b1;
            end
        end
    end

    assign blk_done_o = done_q;
    assign state_o    = state_q;

    // Illegal code length on a forwarded beat (the datapath clamps it).
    len_legal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fwd_vld && (src_len_i[sel] > LEN_MAX)));

`ifdef EBPC_ARB_STATS_EN
    logic [1:0][31:0] stat_bits_q;
    logic [1:0][15:0] stat_pkts_q;

    // Per-source bit and packet counters; clear wins over an increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_bits_q <= '0;
            stat_pkts_q <= '0;
        end else if (stat_clr_i) begin
            stat_bits_q <= '0;
            stat_pkts_q <= '0;
        end else if (xfer) begin
            stat_bits_q[sel] <= stat_bits_q[sel] + 32'(beat.len);
            if (beat.last) begin
                stat_pkts_q[sel] <= stat_pkts_q[sel] + 16'd1;
            end
        end
    end

    assign stat_bits_o = stat_bits_q;
    assign stat_pkts_o = stat_pkts_q;
`endif

endmodule

// File: tb/tb_shift_streamer_arb.sv
// Directed bench for shift_streamer_arb: grant order, flush sequencing,
// empty-block skip, backpressure, zero-length beats and mid-drain reset.
module tb_shift_streamer_arb;
    import ebpc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0][7:0]  src_data_i = '0;
    logic [1:0][3:0]  src_len_i = '0;
    logic [1:0]       src_last_i = '0;
    logic [1:0]       src_vld_i = '0;
    logic [1:0]       src_rdy_o;
    logic             blk_end_i = 1'b0;
    logic             blk_done_o;
    logic [15:0]      str_data_o;
    logic [3:0]       str_shift_o;
    logic             str_flush_o;
    logic             str_vld_o;
    logic             str_rdy_i = 1'b1;
    logic             str_idle_i = 1'b1;
    arb_state_t       state_o;
`ifdef EBPC_ARB_STATS_EN
    logic             stat_clr_i = 1'b0;
    logic [1:0][31:0] stat_bits_o;
    logic [1:0][15:0] stat_pkts_o;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          flush_cnt = 0;
    int          done_cnt = 0;
    logic [63:0] obs_acc = '0;
    logic [1:0]  acc = '0;
    logic [12:0] sq0[$];
    logic [12:0] sq1[$];
    logic [11:0] exp_q[$];

    shift_streamer_arb dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .src_data_i  (src_data_i),
        .src_len_i   (src_len_i),
        .src_last_i  (src_last_i),
        .src_vld_i   (src_vld_i),
        .src_rdy_o   (src_rdy_o),
        .blk_end_i   (blk_end_i),
        .blk_done_o  (blk_done_o),
        .str_data_o  (str_data_o),
        .str_shift_o (str_shift_o),
        .str_flush_o (str_flush_o),
        .str_vld_o   (str_vld_o),
        .str_rdy_i   (str_rdy_i),
        .str_idle_i  (str_idle_i),
        .state_o     (state_o)
`ifdef EBPC_ARB_STATS_EN
        ,
        .stat_clr_i  (stat_clr_i),
        .stat_bits_o (stat_bits_o),
        .stat_pkts_o (stat_pkts_o)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a source beat {last, len, data} and its expected streamer beat.
    task automatic push(input int s, input logic last, input logic [3:0] len, input logic [7:0] data);
        if (s == 0) sq0.push_back({last, len, data});
        else        sq1.push_back({last, len, data});
        exp_q.push_back({len, data});
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || sq0.size() != 0 || sq1.size() != 0 || src_vld_i != 2'b00) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_flush(input string tag, input int target);
        int n = 0;
        while (flush_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(tag, flush_cnt, target);
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic pulse_blk_end();
        @(posedge clk);
        #1 blk_end_i = 1'b1;
        @(posedge clk);
        #1 blk_end_i = 1'b0;
    endtask

    // Handshake sample for the source drivers, away from the clock edge.
    always @(negedge clk) begin
        acc = rst_ni ? (src_vld_i & src_rdy_o) : 2'b00;
    end

    // Source drivers: present the next queued beat once the current one is taken.
    always @(posedge clk) begin
        logic [12:0] b;
        #1;
        if (!rst_ni) begin
            src_vld_i = 2'b00;
        end else begin
            if (!src_vld_i[0] || acc[0]) begin
                if (sq0.size() > 0) begin
                    b = sq0.pop_front();
                    {src_last_i[0], src_len_i[0], src_data_i[0]} = b;
                    src_vld_i[0] = 1'b1;
                end else begin
                    {src_last_i[0], src_len_i[0], src_data_i[0]} = '0;
                    src_vld_i[0] = 1'b0;
                end
            end
            if (!src_vld_i[1] || acc[1]) begin
                if (sq1.size() > 0) begin
                    b = sq1.pop_front();
                    {src_last_i[1], src_len_i[1], src_data_i[1]} = b;
                    src_vld_i[1] = 1'b1;
                end else begin
                    {src_last_i[1], src_len_i[1], src_data_i[1]} = '0;
                    src_vld_i[1] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every streamer beat is checked against the expected queue
    // and its code bits are appended to the packed output stream.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_ni && blk_done_o) done_cnt++;
        if (rst_ni && str_vld_o && str_rdy_i) begin
            if (str_flush_o) begin
                flush_cnt++;
                chk("flush_shift", 32'(str_shift_o), 32'd0);
                chk("flush_data", 32'(str_data_o), 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_beat", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {12'd0, str_shift_o, str_data_o}, {12'd0, e[11:8], e[7:0], 8'h00});
                obs_acc = (obs_acc << str_shift_o) | (64'(str_data_o[15:8]) >> (4'd8 - str_shift_o));
            end
        end
    end

    initial begin
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(blk_done_o), 32'd0);
        chk("rst_vld", 32'(str_vld_o), 32'd0);
        chk("rst_flush", 32'(str_flush_o), 32'd0);
        chk("rst_rdy", 32'(src_rdy_o), 32'd0);
        chk("rst_data", 32'(str_data_o), 32'd0);
        chk("rst_shift", 32'(str_shift_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'(IDLE));
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Empty block: no flush beat, done pulses the cycle after flush_pend
        pulse_blk_end();
        @(negedge clk);
        chk("t3_done_early", 32'(blk_done_o), 32'd0);
        chk("t3_no_vld", 32'(str_vld_o), 32'd0);
        @(negedge clk);
        chk("t3_done_pulse", 32'(blk_done_o), 32'd1);
        chk("t3_no_vld2", 32'(str_vld_o), 32'd0);
        @(negedge clk);
        chk("t3_done_single", 32'(blk_done_o), 32'd0);
        chk("t3_no_flush", flush_cnt, 32'd0);

        // Zero-length beats only: forwarded, but the block needs no flush
        @(negedge clk);
        push(1, 1'b0, 4'd0, 8'h00);
        push(1, 1'b1, 4'd0, 8'h00);
        wait_drained("t5_drained");
        base = done_cnt;
        pulse_blk_end();
        wait_done("t5_done", base + 1);
        chk("t5_no_flush", flush_cnt, 32'd0);

        // Both sources valid: src0's 3-beat packet first, then src1
        @(negedge clk);
        push(0, 1'b0, 4'd5, 8'hB0);
        push(0, 1'b0, 4'd8, 8'h5A);
        push(0, 1'b1, 4'd2, 8'hC0);
        push(1, 1'b1, 4'd4, 8'h90);
        @(negedge clk);
        chk("t1_rdy_b0", 32'(src_rdy_o), 32'b01);
        chk("t1_shift_b0", 32'(str_shift_o), 32'd5);
        @(negedge clk);
        chk("t1_rdy_b1", 32'(src_rdy_o), 32'b01);
        @(negedge clk);
        chk("t1_rdy_b2", 32'(src_rdy_o), 32'b01);
        chk("t1_shift_b2", 32'(str_shift_o), 32'd2);
        @(negedge clk);
        chk("t1_rdy_src1", 32'(src_rdy_o), 32'b10);
        chk("t1_shift_src1", 32'(str_shift_o), 32'd4);
        wait_drained("t1_drained");

        // blk_end mid-packet: packet completes, one flush, done after idle
        base = done_cnt;
        @(negedge clk);
        push(1, 1'b0, 4'd3, 8'hA0);
        push(1, 1'b0, 4'd6, 8'hCC);
        push(1, 1'b1, 4'd7, 8'hE2);
        @(posedge clk);
        @(posedge clk);
        #1 blk_end_i = 1'b1;
        str_idle_i = 1'b0;
        @(posedge clk);
        #1 blk_end_i = 1'b0;
        wait_flush("t2_flush", 1);
        chk("t2_beats_before_flush", exp_q.size(), 32'd0);
        @(negedge clk);
        chk("t2_drain_state", 32'(state_o), 32'(DRAIN));
        chk("t2_no_done_busy", 32'(blk_done_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 str_idle_i = 1'b1;
        wait_done("t2_done", base + 1);
        repeat (5) @(posedge clk);
        chk("t2_done_once", done_cnt, base + 1);
        chk("t2_flush_once", flush_cnt, 32'd1);

        // Backpressure mid-packet: beat held, nothing lost or duplicated
        @(negedge clk);
        obs_acc = '0;
        push(0, 1'b0, 4'd4, 8'hA0);
        push(0, 1'b0, 4'd8, 8'h3C);
        push(0, 1'b0, 4'd8, 8'hF0);
        push(0, 1'b0, 4'd8, 8'h0F);
        push(0, 1'b1, 4'd4, 8'h50);
        repeat (3) @(posedge clk);
        #1 str_rdy_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_rdy_low", 32'(src_rdy_o), 32'd0);
            chk("t4_vld_held", 32'(str_vld_o), 32'd1);
            chk("t4_data_held", {12'd0, str_shift_o, str_data_o}, {12'd0, 4'd8, 16'hF000});
            @(posedge clk);
        end
        #1 str_rdy_i = 1'b1;
        wait_drained("t4_drained");
        chk("t4_packed", obs_acc[31:0], 32'hA3CF00F5);

        // Reset while draining: outputs clear, pending flush is lost
        @(posedge clk);
        #1 str_idle_i = 1'b0;
        blk_end_i = 1'b1;
        @(posedge clk);
        #1 blk_end_i = 1'b0;
        wait_flush("t6_flush", 2);
        #1;
        chk("t6_in_drain", 32'(state_o), 32'(DRAIN));
        base = done_cnt;
        rst_ni = 1'b0;
        @(negedge clk);
        chk("t6_rst_state", 32'(state_o), 32'(IDLE));
        chk("t6_rst_vld", 32'(str_vld_o), 32'd0);
        chk("t6_rst_flush", 32'(str_flush_o), 32'd0);
        chk("t6_rst_done", 32'(blk_done_o), 32'd0);
        chk("t6_rst_rdy", 32'(src_rdy_o), 32'd0);
        chk("t6_rst_data", {12'd0, str_shift_o, str_data_o}, 32'd0);
`ifdef EBPC_ARB_STATS_EN
        chk("t6_rst_bits", stat_bits_o[0], 32'd0);
        chk("t6_rst_pkts", 32'(stat_pkts_o[0]), 32'd0);
`endif
        @(posedge clk);
        #1 rst_ni = 1'b1;
        str_idle_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            push(0, (i == 9), 4'd8, 8'(i * 19 + 1));
        end
        wait_drained("t6_drained");
        repeat (5) @(posedge clk);
        chk("t6_flush_lost", flush_cnt, 32'd2);
        chk("t6_no_done", done_cnt, base);
`ifdef EBPC_ARB_STATS_EN
        chk("t6_bits", stat_bits_o[0], 32'd80);
        chk("t6_pkts", 32'(stat_pkts_o[0]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_streamer_arb.md
Name: shift_streamer_arb

Overview:
- Shares one shift_streamer packing datapath between two variable-length code sources in the encoder: source 0 (ZNZ/run-length coder) and source 1 (bit-plane coder).
- Grants the streamer packet-wise with round-robin priority.
- Presents each code beat as a {code, shift} pair and sequences end-of-block flushes.
- Waits for the streamer to drain (idle) before granting the next block.

Parameters:
- DATA_W, 8: code/output word width; taken from ebpc_pkg, not overridable per instance.
- LW, $clog2(DATA_W+1): width of a code length field (derived localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- src_data_i  in  2 x DATA_W  per-source code, MSB-aligned, unused LSBs zero
- src_len_i  in  2 x LW  per-source code length, 0..DATA_W
- src_last_i  in  2  beat ends the source's current packet
- src_vld_i  in  2  per-source valid
- src_rdy_o  out  2  per-source ready
- blk_end_i  in  1  single-cycle pulse: block complete, flush required
- blk_done_o  out  1  single-cycle pulse: flush drained, streamer idle
- str_data_o  out  2*DATA_W  to streamer data_i: {code, DATA_W zeros}
- str_shift_o  out  LW  to streamer shift_i
- str_flush_o  out  1  to streamer flush_i
- str_vld_o  out  1  to streamer vld_i
- str_rdy_i  in  1  from streamer rdy_o
- str_idle_i  in  1  from streamer idle_o

Behaviour:
- Reset values:
  - State IDLE; rr pointer = 0; dirty = 0; flush_pend = 0.
  - All outputs 0 except str_data_o = 0 and str_shift_o = 0.
- Combinational path: selected source's data/len/vld drive the streamer; str_rdy_i returns only to the granted source's src_rdy_o. Zero added latency.
- Handshake rules:
  - A beat transfers when str_vld_o && str_rdy_i.
  - Ungranted sources see rdy = 0.
  - src_vld_i/data must stay stable until accepted.
- State machine:
  - IDLE: if flush_pend, go to FLUSH. Otherwise grant the valid source with priority from rr; if both are valid, rr wins. Go to LOCK(g) in the same cycle: the grant is combinational, so the first beat may transfer in the IDLE cycle.
  - LOCK(g): forward source g.
    - A transferred beat with src_last_i[g] = 1 sets rr = ~g and returns to IDLE.
    - No preemption mid-packet.
  - FLUSH: drive str_vld_o = 1, str_flush_o = 1, str_shift_o = 0, str_data_o = 0; source rdys = 0. On str_rdy_i, go to DRAIN.
  - DRAIN: wait for str_idle_i = 1, then pulse blk_done_o, clear flush_pend and dirty, go to IDLE.
- Flush bookkeeping:
  - blk_end_i sets flush_pend; it is sampled in any state and is honoured only at a packet boundary (IDLE).
  - dirty is set on any transferred beat with len > 0.
  - If flush_pend && !dirty in IDLE: skip FLUSH/DRAIN, pulse blk_done_o next cycle, clear flush_pend. No spurious zero word is emitted.
- Simultaneous events:
  - blk_end_i in the same cycle as a last beat: the packet completes, then FLUSH follows.
  - blk_end_i while already flush_pend: ignored (no counting).
- len = 0 beats: forwarded normally (the streamer accepts them); they do not set dirty.
- Input checking: src_len_i > DATA_W is illegal. A simulation-only assertion fires; the RTL clamps it to DATA_W.
- Reset mid-operation: returns to IDLE, the pending flush is lost. The streamer is reset by the same rst_ni.

Optional Feature:
- Macro: EBPC_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_bits_o: 2 x 32, per-source total transferred code bits.
  - stat_pkts_o: 2 x 16, per-source completed packets.
  - stat_clr_i: input, synchronous clear.
- Counters wrap modulo 2^width. Clear has priority over a simultaneous increment, and counters reset to 0.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- ebpc_pkg holds:
  - DATA_W and LW.
  - The arb_state_t enum {IDLE, LOCK, FLUSH, DRAIN}.
  - The code_beat_t struct {data, len, last}.
- One sub-module, rr_arb2: a 2-way round-robin grant with a registered pointer, updated on a last-beat handshake.
- Stats counters stay inline.

Test Plan:
1. Both sources valid from reset; src0 sends 3 beats (len 5,8,2, last on 3rd) and src1 sends 1 beat (len 4, last) -> rr = 0 grants src0 first; 3 beats go out, then src1's beat; src1 rdy stays 0 during src0's packet.
2. blk_end_i pulsed mid-packet of src1 (2 beats left) -> both beats complete, then one flush beat (shift 0, flush 1); after str_idle_i, blk_done_o pulses exactly once.
3. blk_end_i with no beats since reset -> no str_vld_o; blk_done_o pulses the next cycle.
4. Streamer backpressure: str_rdy_i low for 4 cycles mid-packet -> src_rdy_o of the granted source is low; data held; no beat lost or duplicated (scoreboard of a packed 32-bit output stream matches the concatenated codes).
5. Only len = 0 beats, then blk_end_i -> no flush beat; blk_done_o pulses.
6. rst_ni asserted while in DRAIN -> all outputs 0 and state IDLE on the next edge; with EBPC_ARB_STATS_EN, counters are 0; after 10 beats of len 8 from src0, stat_bits_o[0] = 80.
